// File: rtl/ram8_write_bank.sv
// Burst write bank: steers handshaked data beats into eight storage words, wrapping modulo 8.
// Optional macro RAM8WB_READBACK_EN adds rd_addr/rd_data through the 8-way read mux.

`ifdef RAM8WB_READBACK_EN
module ram8_read_mux #(
  parameter int WIDTH = 16
) (
  input  logic [8*WIDTH-1:0] d,
  input  logic [2:0]         sel,
  output logic [WIDTH-1:0]   y
);
  logic [WIDTH-1:0] words [8];

  for (genvar i = 0; i < 8; i++) begin : g_unpack
    assign words[i] = d[i*WIDTH +: WIDTH];
  end

  assign y = words[sel];
endmodule
`endif

module ram8_write_bank #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_addr,
  input  logic [2:0]           cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 clr,
  output logic                 done,
  output logic                 busy,
  output logic [7:0]           written,
  output logic [8*WIDTH-1:0]   q
`ifdef RAM8WB_READBACK_EN
  ,
  input  logic [2:0]           rd_addr,
  output logic [WIDTH-1:0]     rd_data
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       remaining;
  logic [WIDTH-1:0] mem [NWORDS];
  logic             cmd_fire;
  logic             beat_fire;
  logic             last_beat;

  // Handshakes use the registered state directly so no path loops through the ready outputs.
  assign cmd_fire  = cmd_valid & (state == IDLE);
  assign beat_fire = wr_valid & (state == DATA);
  assign last_beat = beat_fire & (remaining == 3'd0);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire) state_nxt = DATA;
      end
      DATA: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      remaining <= 3'd0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      // A cleared burst is abandoned, so it never reports completion.
      done  <= last_beat & ~clr;
      if (clr) begin
        ptr       <= 3'd0;
        remaining <= 3'd0;
      end else if (cmd_fire) begin
        ptr       <= cmd_addr;
        remaining <= cmd_len;
      end else if (beat_fire) begin
        ptr <= ptr + 3'd1;
        if (remaining != 3'd0) remaining <= remaining - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
      written <= 8'h00;
    end else if (clr) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
      written <= 8'h00;
    end else if (beat_fire) begin
      mem[ptr]     <= wr_data;
      written[ptr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NWORDS; i++) begin : g_q
    assign q[i*WIDTH +: WIDTH] = mem[i];
  end

`ifdef RAM8WB_READBACK_EN
  ram8_read_mux #(
    .WIDTH(WIDTH)
  ) u_rd_mux (
    .d  (q),
    .sel(rd_addr),
    .y  (rd_data)
  );
`endif

endmodule
